// File: rtl/ctech_lib_mux2_sched_pkg.sv
// rtl/ctech_lib_mux2_sched_pkg.sv - shared types and helpers for the two-requester round-robin scheduler
package ctech_lib_mux2_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } sched_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // Beat counter must be able to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ctech_lib_mux2_bus.sv
// rtl/ctech_lib_mux2_bus.sv - W-bit 2:1 bus mux assembled from per-bit mux cells
module ctech_lib_mux2_bus #(
    parameter int W = 9
) (
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic         s_i,
    output logic [W-1:0] z_o
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        ctech_lib_mux_2to1 u_cell (
            .d1_i (d1_i[gi]),
            .d2_i (d2_i[gi]),
            .s_i  (s_i),
            .z_o  (z_o[gi])
        );
    end

endmodule

// File: rtl/ctech_lib_mux_2to1.sv
// rtl/ctech_lib_mux_2to1.sv - single-bit 2:1 mux cell (s=0 selects d1, s=1 selects d2)
module ctech_lib_mux_2to1 (
    input  logic d1_i,
    input  logic d2_i,
    input  logic s_i,
    output logic z_o
);

    assign z_o = s_i ? d2_i : d1_i;

endmodule

// File: rtl/ctech_lib_mux2_rr_sched.sv
// rtl/ctech_lib_mux2_rr_sched.sv - round-robin burst scheduler sharing one 2:1 mux into a registered output stage
module ctech_lib_mux2_rr_sched
    import ctech_lib_mux2_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    localparam int                 CNT_W   = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]   ONE_CNT = CNT_W'(1);

    sched_state_e     state_q, state_d;
    req_id_t          ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    req_id_t          out_src_q;

    req_id_t          sel;
    logic             load;
    logic             rdy0, rdy1;
    logic             xfer;
    logic [WIDTH:0]   mux_z;

    // Output slot can take a new beat when empty or being drained this cycle.
    assign load = out_ready | ~out_valid_q;

    ctech_lib_mux2_bus #(
        .W (WIDTH + 1)
    ) u_bus (
        .d1_i ({req0_last, req0_data}),
        .d2_i ({req1_last, req1_data}),
        .s_i  (sel),
        .z_o  (mux_z)
    );

    // Select and readies depend only on state, valids and load.
    always_comb begin
        sel  = REQ0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid & req1_valid) begin
                    sel = ~ptr_q;
                end else if (req1_valid) begin
                    sel = REQ1;
                end else begin
                    sel = REQ0;
                end
                rdy0 = load & req0_valid & (sel == REQ0);
                rdy1 = load & req1_valid & (sel == REQ1);
            end
            ST_OWN0: begin
                sel  = REQ0;
                rdy0 = load;
            end
            ST_OWN1: begin
                sel  = REQ1;
                rdy1 = load;
            end
            default: begin
                sel  = REQ0;
                rdy0 = 1'b0;
                rdy1 = 1'b0;
            end
        endcase
    end

    assign xfer = (rdy0 & req0_valid) | (rdy1 & req1_valid);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                if (mux_z[WIDTH] || (MAX_BURST == 1)) begin
                    ptr_d = sel;
                end else begin
                    state_d = (sel == REQ0) ? ST_OWN0 : ST_OWN1;
                    cnt_d   = ONE_CNT;
                end
            end else begin
                cnt_d = cnt_q + ONE_CNT;
                // A cut burst releases the lock without marking the beat as last.
                if (mux_z[WIDTH] || ((cnt_q + ONE_CNT) == MAX_CNT)) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            ptr_q       <= REQ1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= REQ0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (load) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= mux_z[WIDTH-1:0];
                    out_last_q <= mux_z[WIDTH];
                    out_src_q  <= sel;
                end
            end
        end
    end

    assign req0_ready = rst_b & rdy0;
    assign req1_ready = rst_b & rdy1;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_src    = out_src_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ctech_lib_mux2_rr_sched.sv
// tb/tb_ctech_lib_mux2_rr_sched.sv - self-checking bench: vector table, corner sequences, randomized run vs reference model
module tb_ctech_lib_mux2_rr_sched;

    logic clk = 1'b0;
    logic rst_b;
    logic v0, l0, v1, l1, oready;
    logic [7:0] d0, d1;

    logic [1:0]      rdy0_w, rdy1_w, ov_w, ol_w, os_w, busy_w;
    logic [1:0][7:0] od_w;

    always #5 clk = ~clk;

    ctech_lib_mux2_rr_sched #(.WIDTH(8), .MAX_BURST(16)) u_dut_a (
        .clk(clk), .rst_b(rst_b),
        .req0_valid(v0), .req0_data(d0), .req0_last(l0), .req0_ready(rdy0_w[0]),
        .req1_valid(v1), .req1_data(d1), .req1_last(l1), .req1_ready(rdy1_w[0]),
        .out_valid(ov_w[0]), .out_data(od_w[0]), .out_last(ol_w[0]), .out_src(os_w[0]),
        .out_ready(oready), .busy(busy_w[0])
    );

    ctech_lib_mux2_rr_sched #(.WIDTH(8), .MAX_BURST(2)) u_dut_b (
        .clk(clk), .rst_b(rst_b),
        .req0_valid(v0), .req0_data(d0), .req0_last(l0), .req0_ready(rdy0_w[1]),
        .req1_valid(v1), .req1_data(d1), .req1_last(l1), .req1_ready(rdy1_w[1]),
        .out_valid(ov_w[1]), .out_data(od_w[1]), .out_last(ol_w[1]), .out_src(os_w[1]),
        .out_ready(oready), .busy(busy_w[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference: owner (-1 = nobody), beats taken under the lock, last winner, output slot.
    int         m_own[2], m_held[2], m_lastw[2];
    int         max_b[2] = '{16, 2};
    bit         m_ov[2], m_ol[2], m_os[2];
    logic [7:0] m_od[2];
    bit         m_tx[2][2];
    logic       s_rdy0[2], s_rdy1[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_held[k] = 0; m_lastw[k] = 1;
            m_ov[k] = 0; m_ol[k] = 0; m_os[k] = 0; m_od[k] = 8'h00;
            m_tx[k][0] = 0; m_tx[k][1] = 0;
        end
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        v0 = 1; v1 = 1; d0 = 8'hFF; d1 = 8'hEE; l0 = 0; l1 = 0; oready = 1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_out_valid%0d", k), ov_w[k], 0);
            chk($sformatf("reset_busy%0d", k), busy_w[k], 0);
            chk($sformatf("reset_ready0_%0d", k), rdy0_w[k], 0);
            chk($sformatf("reset_ready1_%0d", k), rdy1_w[k], 0);
            chk($sformatf("reset_out_data%0d", k), od_w[k], 0);
            chk($sformatf("reset_out_last%0d", k), ol_w[k], 0);
            chk($sformatf("reset_out_src%0d", k), os_w[k], 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        v0 = 0; v1 = 0;
    endtask

    // One clock: check readies against the model, then check the registered outputs.
    task automatic step();
        bit         ld[2];
        int         win[2];
        bit         vv[2], ll[2];
        logic [7:0] dd[2];
        vv[0] = v0; vv[1] = v1; ll[0] = l0; ll[1] = l1; dd[0] = d0; dd[1] = d1;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit r[2];
            r[0] = 0; r[1] = 0; win[k] = -1;
            ld[k] = oready || !m_ov[k];
            if (ld[k]) begin
                if (m_own[k] >= 0)             win[k] = m_own[k];
                else if (vv[0] && vv[1])       win[k] = (m_lastw[k] == 0) ? 1 : 0;
                else if (vv[0])                win[k] = 0;
                else if (vv[1])                win[k] = 1;
                if (win[k] >= 0) r[win[k]] = 1;
            end
            s_rdy0[k] = rdy0_w[k];
            s_rdy1[k] = rdy1_w[k];
            chk($sformatf("ready0_inst%0d", k), rdy0_w[k], r[0]);
            chk($sformatf("ready1_inst%0d", k), rdy1_w[k], r[1]);
            m_tx[k][0] = r[0] && vv[0];
            m_tx[k][1] = r[1] && vv[1];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (ld[k]) m_ov[k] = m_tx[k][0] || m_tx[k][1];
            if (win[k] >= 0 && m_tx[k][win[k]]) begin
                int w;
                w = win[k];
                m_od[k] = dd[w]; m_ol[k] = ll[w]; m_os[k] = (w == 1);
                if (m_own[k] < 0) begin
                    if (ll[w] || max_b[k] == 1) m_lastw[k] = w;
                    else begin m_own[k] = w; m_held[k] = 1; end
                end else begin
                    m_held[k]++;
                    if (ll[w] || m_held[k] == max_b[k]) begin
                        m_own[k] = -1; m_lastw[k] = w; m_held[k] = 0;
                    end
                end
            end
            chk($sformatf("out_valid_inst%0d", k), ov_w[k], m_ov[k]);
            chk($sformatf("out_data_inst%0d", k), od_w[k], m_od[k]);
            chk($sformatf("out_last_inst%0d", k), ol_w[k], m_ol[k]);
            chk($sformatf("out_src_inst%0d", k), os_w[k], m_os[k]);
            chk($sformatf("busy_inst%0d", k), busy_w[k], (m_own[k] >= 0));
        end
    endtask

    typedef struct packed {
        logic       v0; logic [7:0] d0; logic l0;
        logic       v1; logic [7:0] d1; logic l1;
        logic       ordy;
        logic       e_r0; logic e_r1; logic e_ov; logic [7:0] e_od;
        logic       e_ol; logic e_os; logic e_busy;
    } vec_t;

    vec_t       tbl[10];
    logic [8:0] q0[$], q1[$];
    logic [9:0] cap[$];
    logic [7:0] cons[$];

    initial begin
        // in: v0 d0 l0 v1 d1 l1 ordy | exp: r0 r1 ov od ol os busy (instance with MAX_BURST=16)
        tbl[0] = '{1, 8'hA5, 1, 1, 8'h3C, 1, 1,  1, 0, 1, 8'hA5, 1, 0, 0};
        tbl[1] = '{1, 8'hA5, 1, 1, 8'h3C, 1, 1,  0, 1, 1, 8'h3C, 1, 1, 0};
        tbl[2] = '{1, 8'hA5, 1, 1, 8'h3C, 1, 1,  1, 0, 1, 8'hA5, 1, 0, 0};
        tbl[3] = '{1, 8'hA5, 1, 1, 8'h3C, 1, 1,  0, 1, 1, 8'h3C, 1, 1, 0};
        tbl[4] = '{1, 8'h01, 0, 1, 8'h77, 1, 1,  1, 0, 1, 8'h01, 0, 0, 1};
        tbl[5] = '{1, 8'h02, 0, 1, 8'h77, 1, 1,  1, 0, 1, 8'h02, 0, 0, 1};
        tbl[6] = '{1, 8'h03, 0, 1, 8'h77, 1, 1,  1, 0, 1, 8'h03, 0, 0, 1};
        tbl[7] = '{1, 8'h04, 1, 1, 8'h77, 1, 1,  1, 0, 1, 8'h04, 1, 0, 0};
        tbl[8] = '{0, 8'h00, 0, 1, 8'h77, 1, 1,  0, 1, 1, 8'h77, 1, 1, 0};
        tbl[9] = '{0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h77, 1, 1, 0};

        rst_b = 1'b1;
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; l0 = 0; l1 = 0; oready = 1;
        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            v0 = tbl[i].v0; d0 = tbl[i].d0; l0 = tbl[i].l0;
            v1 = tbl[i].v1; d1 = tbl[i].d1; l1 = tbl[i].l1;
            oready = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d_ready0", i), s_rdy0[0], tbl[i].e_r0);
            chk($sformatf("tbl%0d_ready1", i), s_rdy1[0], tbl[i].e_r1);
            chk($sformatf("tbl%0d_out_valid", i), ov_w[0], tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i), od_w[0], tbl[i].e_od);
            chk($sformatf("tbl%0d_out_last", i), ol_w[0], tbl[i].e_ol);
            chk($sformatf("tbl%0d_out_src", i), os_w[0], tbl[i].e_os);
            chk($sformatf("tbl%0d_busy", i), busy_w[0], tbl[i].e_busy);
        end

        // Forced release on the MAX_BURST=2 instance; sources follow that instance.
        do_reset();
        q0 = '{9'h011, 9'h012, 9'h013, 9'h014, 9'h115};
        q1 = '{9'h199};
        cap.delete();
        for (int c = 0; c < 12; c++) begin
            v0 = (q0.size() > 0);
            {l0, d0} = v0 ? q0[0] : 9'h000;
            v1 = (c >= 1) && (q1.size() > 0);
            {l1, d1} = v1 ? q1[0] : 9'h000;
            oready = 1;
            step();
            if (m_tx[1][0]) void'(q0.pop_front());
            if (m_tx[1][1]) void'(q1.pop_front());
            if (ov_w[1]) cap.push_back({os_w[1], ol_w[1], od_w[1]});
        end
        begin
            logic [9:0] exp_cut[6];
            exp_cut = '{10'h011, 10'h012, 10'h399, 10'h013, 10'h014, 10'h115};
            chk("cut_beat_count", cap.size(), 6);
            for (int i = 0; i < 6; i++)
                chk($sformatf("cut_beat%0d", i), (i < cap.size()) ? cap[i] : 10'h3FF, exp_cut[i]);
        end

        // Consumer stall for three clocks while a beat is held.
        do_reset();
        q0 = '{9'h021, 9'h022, 9'h023, 9'h124};
        cons.delete();
        for (int c = 0; c < 10; c++) begin
            v0 = (q0.size() > 0);
            {l0, d0} = v0 ? q0[0] : 9'h000;
            v1 = 0; d1 = 0; l1 = 0;
            oready = !(c >= 2 && c <= 4);
            if (ov_w[0] && oready) cons.push_back(od_w[0]);
            step();
            if (m_tx[0][0]) void'(q0.pop_front());
            if (c >= 2 && c <= 4) begin
                chk($sformatf("stall_ready0_c%0d", c), s_rdy0[0], 0);
                chk($sformatf("stall_data_c%0d", c), od_w[0], 8'h22);
                chk($sformatf("stall_valid_c%0d", c), ov_w[0], 1);
            end
        end
        begin
            logic [7:0] exp_st[4];
            exp_st = '{8'h21, 8'h22, 8'h23, 8'h24};
            chk("stall_consumed_count", cons.size(), 4);
            for (int i = 0; i < 4; i++)
                chk($sformatf("stall_consumed%0d", i), (i < cons.size()) ? cons[i] : 8'hFF, exp_st[i]);
        end

        // Owner req1 drops valid mid-burst; req0 must stay blocked.
        do_reset();
        q1 = '{9'h031, 9'h032, 9'h033, 9'h134};
        cap.delete();
        for (int c = 0; c < 14; c++) begin
            v0 = (c >= 1); d0 = 8'h55; l0 = 1;
            v1 = (q1.size() > 0) && !(c >= 2 && c <= 6);
            {l1, d1} = v1 ? q1[0] : 9'h000;
            oready = 1;
            step();
            if (m_tx[0][1]) void'(q1.pop_front());
            if (ov_w[0]) cap.push_back({os_w[0], ol_w[0], od_w[0]});
            if (c >= 2 && c <= 6) begin
                chk($sformatf("drop_ready0_c%0d", c), s_rdy0[0], 0);
                chk($sformatf("drop_busy_c%0d", c), busy_w[0], 1);
                chk($sformatf("drop_out_valid_c%0d", c), ov_w[0], 0);
            end
        end
        begin
            logic [9:0] exp_dr[5];
            exp_dr = '{10'h231, 10'h232, 10'h233, 10'h334, 10'h155};
            chk("drop_enough_beats", cap.size() >= 5, 1);
            for (int i = 0; i < 5; i++)
                chk($sformatf("drop_beat%0d", i), (i < cap.size()) ? cap[i] : 10'h3FF, exp_dr[i]);
        end

        // Asynchronous reset while instance A owns a burst with a beat in flight.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            v0 = 1; d0 = 8'h41 + 8'(c); l0 = 0; v1 = 0; d1 = 0; l1 = 0; oready = 1;
            step();
        end
        chk("mid_reset_pre_busy", busy_w[0], 1);
        chk("mid_reset_pre_valid", ov_w[0], 1);
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        chk("mid_reset_out_valid", ov_w[0], 0);
        chk("mid_reset_busy", busy_w[0], 0);
        chk("mid_reset_ready0", rdy0_w[0], 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        v0 = 1; d0 = 8'h5A; l0 = 1; v1 = 1; d1 = 8'hA5; l1 = 1; oready = 1;
        step();
        chk("post_reset_tie_ready0", s_rdy0[0], 1);
        chk("post_reset_tie_ready1", s_rdy1[0], 0);
        chk("post_reset_tie_src", os_w[0], 0);
        chk("post_reset_tie_data", od_w[0], 8'h5A);

        // Randomized traffic on both instances against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            v0 = ($urandom_range(0, 3) != 0);
            d0 = 8'($urandom);
            l0 = ($urandom_range(0, 2) == 0);
            v1 = ($urandom_range(0, 3) != 0);
            d1 = 8'($urandom);
            l1 = ($urandom_range(0, 2) == 0);
            oready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctech_lib_mux2_rr_sched.md
Name: ctech_lib_mux2_rr_sched

Overview:
Two-requester round-robin scheduler that shares one 2:1 mux datapath between two valid/ready burst sources. It drives the mux select and holds it for a whole burst until last, or until MAX_BURST beats when the burst is cut short. Mux output lands in a single registered output stage with valid/ready toward the consumer. It is a library-level building block that sits directly in front of shared sinks (one write port, one serializer lane).

Parameters:
WIDTH, 8, payload bits per beat (>=1)
MAX_BURST, 16, max beats one owner holds the lock before forced release (>=1)

Ports:
clk  input  1  block clock, all state on rising edge
rst_b  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 beat valid
req0_data  input  WIDTH  requester 0 payload
req0_last  input  1  requester 0 final beat of burst
req0_ready  output  1  requester 0 beat accepted this cycle
req1_valid  input  1  requester 1 beat valid
req1_data  input  WIDTH  requester 1 payload
req1_last  input  1  requester 1 final beat of burst
req1_ready  output  1  requester 1 beat accepted this cycle
out_valid  output  1  registered beat valid
out_data  output  WIDTH  registered payload
out_last  output  1  registered copy of source last
out_src  output  1  source of registered beat (0/1)
out_ready  input  1  consumer accepts out beat
busy  output  1  lock held (state != IDLE)

Behaviour:
- Reset (rst_b low, async): state IDLE; ptr=1, so req0 wins the first tie; cnt=0; out_valid=0, out_data=0, out_last=0, out_src=0, busy=0. req*_ready forced 0 while rst_b is low.
- load = out_ready | ~out_valid. A beat transfers from requester i when reqi_valid & reqi_ready.
- The req*_ready signals are combinational from state, valid and load. No combinational path from req*_data to any output.
- IDLE:
  - If load and only one valid, grant that one.
  - If load and both valid, grant ~ptr.
  - The granted requester's ready=1 and its beat transfers in the same cycle.
  - If the beat is last or MAX_BURST==1: stay IDLE, ptr<=winner.
  - Otherwise go to OWNi with cnt<=1.
- OWNi:
  - reqi_ready = load; the other requester's ready=0.
  - On transfer, cnt<=cnt+1.
  - If the beat is last or cnt+1==MAX_BURST: go to IDLE, ptr<=i, cnt<=0.
- Forced release at MAX_BURST: the requester's burst is not ended. Its remaining beats rearbitrate from IDLE, and out_last stays 0 on the cut beat.
- Owner drops valid mid-burst: lock held indefinitely; no timeout; the other requester is blocked.
- Mux select = winner (0 selects req0 / d1, 1 selects req1 / d2). Data and last both go through the mux.
- Output register:
  - On transfer: out_valid<=1, out_data/out_last<=muxed values, out_src<=winner.
  - On load without transfer: out_valid<=0; data regs hold.
  - When out_valid & ~out_ready: everything holds and both readies are 0.
- Throughput: 1 beat/clk when out_ready is high. Latency: input to out_valid is 1 clk.
- busy = (state != IDLE).
- Reset mid-burst: in-flight beat in the output register is discarded; returns to IDLE with ptr=1.
- cnt width = $clog2(MAX_BURST+1). Cannot overflow because release fires at MAX_BURST.

Decomposition:
- Package ctech_lib_mux2_sched_pkg: state enum (IDLE, OWN0, OWN1), requester-id typedef (1-bit), helper function for cnt width.
- Sub-module ctech_lib_mux2_bus: WIDTH+1-bit 2:1 bus mux built as a generate loop of ctech_lib_mux_2to1 cells (d1=req0, d2=req1, s=select). Keeps the cell-level datapath separate from the scheduler FSM.

Test Plan:
- Reset then both requesters valid with single-beat bursts (req0 A5, req1 3C) for 4 clks, out_ready=1 -> out sequence A5(src0), 3C(src1), alternating; 1 beat/clk; out_valid first high 1 clk after reset release.
- req0 4-beat burst 01..04 (last on 04) and req1 valid throughout -> out_src=0 for 4 beats, then req1; busy=1 from the first beat until the 04 transfer.
- MAX_BURST=2, req0 5-beat burst, req1 idle then valid -> after 2 beats release; req1 gets the next beat; req0 resumes; out_last=0 on the cut beats, 1 only on beat 5.
- out_ready held low 3 clks with out_valid=1 -> out_data stable, both readies 0, no beat lost or duplicated, flow resumes on out_ready=1.
- Owner req1 drops valid mid-burst for 5 clks while req0 valid -> req0_ready stays 0, busy=1, no output beats; req1 resumes and finishes with last.
- Assert rst_b low during OWN0 with out_valid=1 -> out_valid=0 immediately, busy=0; after release a tie grants req0.
